riscv_multicycle_ctrl: RTL and testbench
========================================

// Module: riscv_multicycle_ctrl
// PURPOSE
//  Multicycle RISC-V (RV32I subset) main controller; successor to the single-cycle control bus.
//  Moore FSM sequences each instruction over 3-5 cycles, with handshake wait-states on a shared
//  instruction/data memory. Full branch set (beq/bne/blt/bge/bltu/bgeu), lui, shifts, illegal-opcode trap.
//  Drives the multicycle datapath; datapath returns ALU flags and MemReady.
// PARAMETERS
//  ALUCTRL_W    4   ALUControl width; must be >= 4
//  TIMEOUT_CYC  64  MemReady wait limit in cycles (used only with MEM_TIMEOUT_EN)
// PORTS
//  CLK           in   1          clock, rising edge
//  RST           in   1          async reset, active-low
//  OP6_0         in   7          instr opcode, valid while IR is held
//  funct3_2_0    in   3          instr[14:12]
//  funct7_5      in   1          instr[30]
//  Zero          in   1          ALU result == 0
//  Lt            in   1          signed A<B from ALU subtract
//  Ltu           in   1          unsigned A<B from ALU subtract
//  MemReady      in   1          memory completes the current MemReq this cycle
//  MemReq        out  1          memory access request, held until MemReady
//  MemWrite      out  1          qualifies MemReq as store
//  AdrSrc        out  1          0=PC, 1=Result as memory address
//  IRWrite       out  1          load IR and OldPC
//  PCWrite       out  1          PC <= Result
//  RegWrite      out  1          register-file write
//  ALUSrcA1_0    out  2          00=PC 01=OldPC 10=RD1 11=zero
//  ALUSrcB1_0    out  2          00=RD2 01=Imm 10=const 4
//  ResultSrc1_0  out  2          00=ALUOut 01=ReadData 10=ALUResult
//  ImmSrc2_0     out  3          000=I 001=S 010=B 011=J 100=U
//  ALUControl    out  ALUCTRL_W  0 add,1 sub,2 and,3 or,4 xor,5 slt,6 sltu,7 sll,8 srl,9 sra
//  Trap          out  1          sticky; illegal opcode (or timeout)
// BEHAVIOUR
//  - RST low: state=S_RST; all outputs 0; Trap=0. First cycle after release: S_RST->FETCH.
//  - FETCH: MemReq=1, AdrSrc=0, ALU PC+4. Stays until MemReady; on MemReady: IRWrite=1, PCWrite=1, ->DECODE.
//  - DECODE: ALU OldPC+Imm(B/J). Next: lw/sw->MEMADR; R->EXER; I-alu->EXEI; branch->BRANCH;
//    jal->JAL; lui->LUI; other opcode->TRAP.
//  - MEMADR: RD1+Imm. ->MEMRD (lw) / MEMWR (sw).
//  - MEMRD: MemReq=1, AdrSrc=1; on MemReady ->MEMWB. MEMWB: ResultSrc=01, RegWrite=1, ->FETCH.
//  - MEMWR: MemReq=1, MemWrite=1, AdrSrc=1; on MemReady ->FETCH.
//  - EXER/EXEI: ALU decoded from funct3/funct7_5 (funct7_5 selects sub only for R; srai/sra always).
//    ->ALUWB: RegWrite=1, ResultSrc=00, ->FETCH.
//  - BRANCH: ALU sub RD1-RD2, ResultSrc=00. PCWrite=cond: beq Z, bne !Z, blt Lt, bge !Lt,
//    bltu Ltu, bgeu !Ltu; funct3 010/011 -> TRAP. ->FETCH.
//  - JAL: OldPC+4 -> ALUWB, PCWrite=1 (target from ALUOut). LUI: zero+ImmU -> ALUWB.
//  - TRAP: all outputs 0 except Trap=1; stays until reset.
//  - MemReq never drops before MemReady; inputs OP/funct stable since IR written only in FETCH.
//  - MemReady outside a MemReq state is ignored.
//  - ALUControl upper bits beyond 4 driven 0.
// CONFIGURATION
//  MEM_TIMEOUT_EN defined: counter resets on entering a MemReq state. If TIMEOUT_CYC cycles elapse
//    without MemReady, go to TRAP (Trap=1, MemReq drops). MemReady on cycle TIMEOUT_CYC still completes.
//  Undefined: no counter; wait indefinitely.
// STRUCTURE
//  riscv_ctrl_pkg: state enum, opcode constants (LW 0000011, SW 0100011, R 0110011, I 0010011,
//    BR 1100011, JAL 1101111, LUI 0110111), ALUControl/ImmSrc/ResultSrc codes.
//  Sub-module riscv_alu_dec: combinational ALUOp+funct3+funct7_5+op[5] -> ALUControl.
// TESTING
//  1 lw, MemReady late by 3 cycles: FETCH 4 cyc, MEMRD 4 cyc; RegWrite=1 exactly in MEMWB, ResultSrc=01.
//  2 bne funct3=001, Zero=0 -> PCWrite=1 in BRANCH; Zero=1 -> PCWrite=0; bltu with Ltu=1 -> PCWrite=1.
//  3 R sub (funct7_5=1,f3=000) -> ALUControl=1; srai I-type (f3=101,f7_5=1) -> 9; addi f7_5=1 -> 0.
//  4 OP6_0=1111111 -> TRAP next cycle, Trap=1 held; RST pulse -> S_RST, Trap=0, then FETCH.
//  5 RST low mid-MEMWR with MemReq=1 -> MemReq/MemWrite 0 immediately (async).
//  6 MEM_TIMEOUT_EN, TIMEOUT_CYC=8, MemReady stuck 0 in FETCH -> Trap=1 after 8 cycles; undefined -> waits.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multicycle RV32I controller: FSM states,
// opcode constants and the datapath select/ALU codes.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_RST    = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXER   = 4'd7,
        S_EXEI   = 4'd8,
        S_ALUWB  = 4'd9,
        S_BRANCH = 4'd10,
        S_JAL    = 4'd11,
        S_LUI    = 4'd12,
        S_TRAP   = 4'd13
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    // ALUOp from the main FSM to the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_READ   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // States that hold a memory request open until MemReady
    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/riscv_multicycle_ctrl_alu_dec.sv
// ALU decoder: maps ALUOp plus instruction funct fields to an ALUControl code.
// funct7_5 selects sub only for R-type (op5=1); it always selects sra for shifts right.
import riscv_ctrl_pkg::*;

module riscv_alu_dec (
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       op5,
    output logic [3:0] alu_ctl
);

    // Decode the ALU operation from ALUOp and the funct fields
    always_comb begin
        alu_ctl = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_ctl = ALU_ADD;
            ALUOP_SUB: alu_ctl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_ctl = (op5 && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_ctl = ALU_SLL;
                    3'b010:  alu_ctl = ALU_SLT;
                    3'b011:  alu_ctl = ALU_SLTU;
                    3'b100:  alu_ctl = ALU_XOR;
                    3'b101:  alu_ctl = funct7_5 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_ctl = ALU_OR;
                    default: alu_ctl = ALU_AND;
                endcase
            end
            default: alu_ctl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// Multicycle RV32I main controller: Moore FSM sequencing fetch/decode/execute
// over a shared handshaked instruction/data memory.
// Optional MEM_TIMEOUT_EN: traps when a memory request waits TIMEOUT_CYC cycles
// without MemReady; without it the FSM waits indefinitely.
import riscv_ctrl_pkg::*;

module riscv_multicycle_ctrl #(
    parameter int ALUCTRL_W   = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [6:0]           OP6_0,
    input  logic [2:0]           funct3_2_0,
    input  logic                 funct7_5,
    input  logic                 Zero,
    input  logic                 Lt,
    input  logic                 Ltu,
    input  logic                 MemReady,
    output logic                 MemReq,
    output logic                 MemWrite,
    output logic                 AdrSrc,
    output logic                 IRWrite,
    output logic                 PCWrite,
    output logic                 RegWrite,
    output logic [1:0]           ALUSrcA1_0,
    output logic [1:0]           ALUSrcB1_0,
    output logic [1:0]           ResultSrc1_0,
    output logic [2:0]           ImmSrc2_0,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic                 Trap
);

    state_t     state, next;
    logic [1:0] alu_op;
    logic [3:0] alu_ctl;
    logic       timeout;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
    logic [CNT_W-1:0] cnt;

    // Count cycles spent waiting in the current memory state; restart on entry
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)                                       cnt <= '0;
        else if ((next == state) && is_mem_state(state)) cnt <= cnt + 1'b1;
        else                                            cnt <= '0;
    end

    // Last allowed cycle still completes if MemReady arrives in it
    assign timeout = is_mem_state(state) && !MemReady &&
                     (cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    assign timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= S_RST;
        else      state <= next;
    end

    // Next-state and Moore outputs (branch/fetch strobes qualified by inputs)
    always_comb begin
        next         = state;
        alu_op       = ALUOP_ADD;
        MemReq       = 1'b0;
        MemWrite     = 1'b0;
        AdrSrc       = 1'b0;
        IRWrite      = 1'b0;
        PCWrite      = 1'b0;
        RegWrite     = 1'b0;
        ALUSrcA1_0   = SRCA_PC;
        ALUSrcB1_0   = SRCB_RD2;
        ResultSrc1_0 = RES_ALUOUT;
        ImmSrc2_0    = IMM_I;
        Trap         = 1'b0;
        case (state)
            S_RST: next = S_FETCH;
            S_FETCH: begin
                MemReq       = 1'b1;
                ALUSrcB1_0   = SRCB_FOUR;
                ResultSrc1_0 = RES_ALURES;
                if (MemReady) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    next    = S_DECODE;
                end
            end
            S_DECODE: begin
                // Precompute the branch/jump target into ALUOut
                ALUSrcA1_0 = SRCA_OLDPC;
                ALUSrcB1_0 = SRCB_IMM;
                ImmSrc2_0  = (OP6_0 == OP_JAL) ? IMM_J : IMM_B;
                case (OP6_0)
                    OP_LW, OP_SW: next = S_MEMADR;
                    OP_R:         next = S_EXER;
                    OP_I:         next = S_EXEI;
                    OP_BR:        next = S_BRANCH;
                    OP_JAL:       next = S_JAL;
                    OP_LUI:       next = S_LUI;
                    default:      next = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA1_0 = SRCA_RD1;
                ALUSrcB1_0 = SRCB_IMM;
                ImmSrc2_0  = OP6_0[5] ? IMM_S : IMM_I;
                next       = OP6_0[5] ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                MemReq = 1'b1;
                AdrSrc = 1'b1;
                if (MemReady) next = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc1_0 = RES_READ;
                RegWrite     = 1'b1;
                next         = S_FETCH;
            end
            S_MEMWR: begin
                MemReq   = 1'b1;
                MemWrite = 1'b1;
                AdrSrc   = 1'b1;
                if (MemReady) next = S_FETCH;
            end
            S_EXER: begin
                ALUSrcA1_0 = SRCA_RD1;
                ALUSrcB1_0 = SRCB_RD2;
                alu_op     = ALUOP_FUNCT;
                next       = S_ALUWB;
            end
            S_EXEI: begin
                ALUSrcA1_0 = SRCA_RD1;
                ALUSrcB1_0 = SRCB_IMM;
                ImmSrc2_0  = IMM_I;
                alu_op     = ALUOP_FUNCT;
                next       = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                next     = S_FETCH;
            end
            S_BRANCH: begin
                // Compare via subtract; PC takes the target held in ALUOut
                ALUSrcA1_0 = SRCA_RD1;
                ALUSrcB1_0 = SRCB_RD2;
                ImmSrc2_0  = IMM_B;
                alu_op     = ALUOP_SUB;
                next       = S_FETCH;
                case (funct3_2_0)
                    3'b000:  PCWrite = Zero;
                    3'b001:  PCWrite = !Zero;
                    3'b100:  PCWrite = Lt;
                    3'b101:  PCWrite = !Lt;
                    3'b110:  PCWrite = Ltu;
                    3'b111:  PCWrite = !Ltu;
                    default: next    = S_TRAP;
                endcase
            end
            S_JAL: begin
                // Link value OldPC+4 computed now; PC takes the target from ALUOut
                ALUSrcA1_0 = SRCA_OLDPC;
                ALUSrcB1_0 = SRCB_FOUR;
                PCWrite    = 1'b1;
                next       = S_ALUWB;
            end
            S_LUI: begin
                ALUSrcA1_0 = SRCA_ZERO;
                ALUSrcB1_0 = SRCB_IMM;
                ImmSrc2_0  = IMM_U;
                next       = S_ALUWB;
            end
            S_TRAP: Trap = 1'b1;
            default: next = S_RST;
        endcase
        if (timeout) next = S_TRAP;
    end

    riscv_alu_dec u_alu_dec (
        .alu_op   (alu_op),
        .funct3   (funct3_2_0),
        .funct7_5 (funct7_5),
        .op5      (OP6_0[5]),
        .alu_ctl  (alu_ctl)
    );

    // Widen the 4-bit ALU code; upper bits stay zero
    always_comb begin
        ALUControl      = '0;
        ALUControl[3:0] = alu_ctl;
    end

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Directed bench for riscv_multicycle_ctrl; expectations queued per cycle and
// checked at the falling edge. Honours MEM_TIMEOUT_EN for the timeout case.
module tb_riscv_multicycle_ctrl;

    localparam int AW = 5;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] JAL = 7'b1101111;
    localparam logic [6:0] LUI = 7'b0110111;
    localparam logic [6:0] BAD = 7'b1111111;

    logic          CLK = 1'b0;
    logic          RST;
    logic [6:0]    OP6_0;
    logic [2:0]    funct3_2_0;
    logic          funct7_5, Zero, Lt, Ltu, MemReady;
    logic          MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, Trap;
    logic [1:0]    ALUSrcA1_0, ALUSrcB1_0, ResultSrc1_0;
    logic [2:0]    ImmSrc2_0;
    logic [AW-1:0] ALUControl;

    riscv_multicycle_ctrl #(.ALUCTRL_W(AW), .TIMEOUT_CYC(8)) dut (
        .CLK(CLK), .RST(RST), .OP6_0(OP6_0), .funct3_2_0(funct3_2_0),
        .funct7_5(funct7_5), .Zero(Zero), .Lt(Lt), .Ltu(Ltu), .MemReady(MemReady),
        .MemReq(MemReq), .MemWrite(MemWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .RegWrite(RegWrite), .ALUSrcA1_0(ALUSrcA1_0),
        .ALUSrcB1_0(ALUSrcB1_0), .ResultSrc1_0(ResultSrc1_0), .ImmSrc2_0(ImmSrc2_0),
        .ALUControl(ALUControl), .Trap(Trap)
    );

    always #5 CLK = ~CLK;

    typedef enum {G_MEMREQ, G_MEMWR, G_ADR, G_IRW, G_PCW, G_REGW,
                  G_SRCA, G_SRCB, G_RES, G_IMM, G_ALU, G_TRAP, G_ALL} sig_e;
    typedef struct {
        string       tag;
        sig_e        sel;
        logic [31:0] exp;
    } sb_t;

    sb_t sbq[$];
    int  n_run  = 0;
    int  n_fail = 0;

    function automatic logic [31:0] obs(input sig_e s);
        case (s)
            G_MEMREQ: return 32'(MemReq);
            G_MEMWR:  return 32'(MemWrite);
            G_ADR:    return 32'(AdrSrc);
            G_IRW:    return 32'(IRWrite);
            G_PCW:    return 32'(PCWrite);
            G_REGW:   return 32'(RegWrite);
            G_SRCA:   return 32'(ALUSrcA1_0);
            G_SRCB:   return 32'(ALUSrcB1_0);
            G_RES:    return 32'(ResultSrc1_0);
            G_IMM:    return 32'(ImmSrc2_0);
            G_ALU:    return 32'(ALUControl);
            G_TRAP:   return 32'(Trap);
            default:  return 32'({MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                                  ALUSrcA1_0, ALUSrcB1_0, ResultSrc1_0, ImmSrc2_0,
                                  ALUControl, Trap});
        endcase
    endfunction

    task automatic ex(input string tag, input sig_e s, input logic [31:0] v);
        sb_t e;
        e.tag = tag; e.sel = s; e.exp = v;
        sbq.push_back(e);
    endtask

    task automatic flush();
        sb_t         e;
        logic [31:0] o;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            o = obs(e.sel);
            n_run++;
            assert (o === e.exp) else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, o, e.exp);
            end
        end
    endtask

    // Check queued expectations mid-cycle, then move to just after the next edge
    task automatic tick();
        @(negedge CLK);
        flush();
        @(posedge CLK);
        #1;
    endtask

    // FETCH with wait-states, then the IR-load cycle with the given instruction
    task automatic fetch(input logic [6:0] op, input logic [2:0] f3, input logic f7, input int waitc);
        MemReady = 1'b0;
        for (int i = 0; i < waitc; i++) begin
            ex("fetch_req", G_MEMREQ, 1); ex("fetch_noir", G_IRW, 0);
            ex("fetch_nopc", G_PCW, 0);   ex("fetch_adr", G_ADR, 0);
            tick();
        end
        MemReady = 1'b1; OP6_0 = op; funct3_2_0 = f3; funct7_5 = f7;
        ex("fetch_ir", G_IRW, 1);  ex("fetch_pc", G_PCW, 1);
        ex("fetch_srcb", G_SRCB, 2); ex("fetch_res", G_RES, 2); ex("fetch_alu", G_ALU, 0);
        tick();
        MemReady = 1'b0;
    endtask

    // Asynchronous reset pulse between edges; outputs must clear at once
    task automatic reset_pulse(input string tag);
        @(negedge CLK);
        flush();
        #2 RST = 1'b0;
        #1 ex(tag, G_ALL, 0);
        flush();
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        ex("after_rst_fetch", G_MEMREQ, 1);
    endtask

    initial begin
        RST = 1'b0; OP6_0 = '0; funct3_2_0 = '0; funct7_5 = 1'b0;
        Zero = 1'b0; Lt = 1'b0; Ltu = 1'b0; MemReady = 1'b0;
        repeat (2) @(posedge CLK);
        #1 MemReady = 1'b1;
        ex("reset_all_zero", G_ALL, 0);
        @(negedge CLK);
        flush();
        MemReady = 1'b0;
        RST = 1'b1;
        @(posedge CLK);
        #1;

        // lw with 3 wait-states on both fetch and data read
        fetch(LW, 3'b010, 1'b0, 3);
        ex("lw_dec_req", G_MEMREQ, 0); ex("lw_dec_srca", G_SRCA, 1); ex("lw_dec_srcb", G_SRCB, 1);
        tick();
        ex("lw_adr_srca", G_SRCA, 2); ex("lw_adr_imm", G_IMM, 0); ex("lw_adr_regw", G_REGW, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            ex("lw_rd_req", G_MEMREQ, 1); ex("lw_rd_adr", G_ADR, 1); ex("lw_rd_regw", G_REGW, 0);
            tick();
        end
        MemReady = 1'b1;
        ex("lw_rd_req_last", G_MEMREQ, 1); ex("lw_rd_wr", G_MEMWR, 0);
        tick();
        MemReady = 1'b0;
        ex("lw_wb_regw", G_REGW, 1); ex("lw_wb_res", G_RES, 1); ex("lw_wb_req", G_MEMREQ, 0);
        tick();
        ex("lw_next_fetch", G_MEMREQ, 1); ex("lw_next_regw", G_REGW, 0);

        // branches
        fetch(BR, 3'b001, 1'b0, 0);
        ex("bne_dec_imm", G_IMM, 2);
        tick();
        Zero = 1'b0;
        ex("bne_taken", G_PCW, 1); ex("br_alu_sub", G_ALU, 1); ex("br_res", G_RES, 0);
        tick();
        fetch(BR, 3'b001, 1'b0, 0);
        tick();
        Zero = 1'b1;
        ex("bne_not_taken", G_PCW, 0);
        tick();
        Zero = 1'b0;
        fetch(BR, 3'b110, 1'b0, 0);
        tick();
        Ltu = 1'b1;
        ex("bltu_taken", G_PCW, 1);
        tick();
        Ltu = 1'b0;
        fetch(BR, 3'b101, 1'b0, 0);
        tick();
        Lt = 1'b1;
        ex("bge_not_taken", G_PCW, 0);
        tick();
        Lt = 1'b0;

        // ALU decode
        fetch(RT, 3'b000, 1'b1, 0);
        tick();
        ex("sub_alu", G_ALU, 1); ex("sub_srca", G_SRCA, 2); ex("sub_srcb", G_SRCB, 0);
        tick();
        ex("sub_wb_regw", G_REGW, 1); ex("sub_wb_res", G_RES, 0);
        tick();
        fetch(IT, 3'b101, 1'b1, 0);
        tick();
        ex("srai_alu", G_ALU, 9); ex("srai_srcb", G_SRCB, 1); ex("srai_imm", G_IMM, 0);
        tick();
        tick();
        fetch(IT, 3'b000, 1'b1, 0);
        tick();
        ex("addi_f7_alu", G_ALU, 0);
        tick();
        tick();
        fetch(RT, 3'b111, 1'b0, 0);
        tick();
        ex("and_alu", G_ALU, 2);
        tick();
        tick();

        // jal and lui
        fetch(JAL, 3'b000, 1'b0, 0);
        ex("jal_dec_imm", G_IMM, 3);
        tick();
        ex("jal_pcw", G_PCW, 1); ex("jal_srca", G_SRCA, 1); ex("jal_srcb", G_SRCB, 2);
        ex("jal_regw", G_REGW, 0);
        tick();
        ex("jal_wb_regw", G_REGW, 1);
        tick();
        fetch(LUI, 3'b000, 1'b0, 0);
        tick();
        ex("lui_srca", G_SRCA, 3); ex("lui_imm", G_IMM, 4); ex("lui_srcb", G_SRCB, 1);
        tick();
        ex("lui_wb_regw", G_REGW, 1);
        tick();

        // sw, reset asserted mid-MEMWR
        fetch(SW, 3'b010, 1'b0, 0);
        tick();
        ex("sw_adr_imm", G_IMM, 1);
        tick();
        ex("sw_req", G_MEMREQ, 1); ex("sw_memwrite", G_MEMWR, 1); ex("sw_adr", G_ADR, 1);
        reset_pulse("sw_async_reset");

        // illegal opcode trap, then reset recovery
        fetch(BAD, 3'b000, 1'b0, 0);
        ex("bad_dec_trap", G_TRAP, 0);
        tick();
        MemReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ex("trap_only", G_ALL, 1);
            tick();
        end
        MemReady = 1'b0;
        reset_pulse("trap_reset");

        // reserved branch funct3 traps
        fetch(BR, 3'b010, 1'b0, 0);
        tick();
        ex("br010_no_pcw", G_PCW, 0);
        tick();
        ex("br010_trap", G_TRAP, 1);
        reset_pulse("br010_reset");

        // memory never ready during fetch
        for (int i = 0; i < 8; i++) begin
            ex("stall_req", G_MEMREQ, 1); ex("stall_notrap", G_TRAP, 0);
            tick();
        end
`ifdef MEM_TIMEOUT_EN
        ex("timeout_trap", G_TRAP, 1); ex("timeout_req", G_MEMREQ, 0);
        tick();
`else
        for (int i = 0; i < 20; i++) begin
            ex("wait_req", G_MEMREQ, 1); ex("wait_notrap", G_TRAP, 0);
            tick();
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
